cpu_axi_rd_nx1_arb: RTL and testbench

//  N-master to 1-slave AXI4 read-channel arbiter. It generalises the fixed two-port instruction/data

---
 rtl/cpu_axi_rd_nx1_arb.sv | 178 +++++++++++++++++
 tb/tb_cpu_axi_rd_nx1_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_rd_nx1_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cpu_axi_rd_nx1_arb
//
// Purpose:
//   N-master to 1-slave AXI4 read-channel arbiter. It allows one burst at a
//   time. In IDLE a winner is picked (round-robin or fixed priority), and the
//   winner's AR fields are captured in the same cycle. The captured request is
//   then presented to the slave. The R beats are routed back to the winner
//   until rlast.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m_araddr/arlen/arsize/arburst  per-port AR fields, port i in slice i
//   m_arvalid / m_arready          per-port AR handshake (ready = capture pulse)
//   m_rdata/rresp/rlast            R payload, broadcast to all ports
//   m_rvalid / m_rready            per-port R handshake, only the owner is live
//   s_axi_ar*                      AR channel towards the slave
//   s_axi_r*, s_axi_rready         R channel from the slave
//   grant_idx                      current or last owner port
//   busy                           high whenever a burst is in flight
// ---------------------------------------------------------------------------
module cpu_axi_rd_nx1_arb #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_araddr,
    input  logic [NUM_PORTS*8-1:0]           m_arlen,
    input  logic [NUM_PORTS*3-1:0]           m_arsize,
    input  logic [NUM_PORTS*2-1:0]           m_arburst,
    input  logic [NUM_PORTS-1:0]             m_arvalid,
    output logic [NUM_PORTS-1:0]             m_arready,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic [1:0]                       m_rresp,
    output logic                             m_rlast,
    output logic [NUM_PORTS-1:0]             m_rvalid,
    input  logic [NUM_PORTS-1:0]             m_rready,
    output logic [ID_WIDTH-1:0]              s_axi_arid,
    output logic [ADDR_WIDTH-1:0]            s_axi_araddr,
    output logic [7:0]                       s_axi_arlen,
    output logic [2:0]                       s_axi_arsize,
    output logic [1:0]                       s_axi_arburst,
    output logic                             s_axi_arvalid,
    input  logic                             s_axi_arready,
    input  logic [ID_WIDTH-1:0]              s_axi_rid,
    input  logic [DATA_WIDTH-1:0]            s_axi_rdata,
    input  logic [1:0]                       s_axi_rresp,
    input  logic                             s_axi_rlast,
    input  logic                             s_axi_rvalid,
    output logic                             s_axi_rready,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_idx,
    output logic                             busy
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]            state_q,   state_d;
    logic [GW-1:0]         grant_q,   grant_d;
    logic [GW-1:0]         rr_ptr_q,  rr_ptr_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic [7:0]            arlen_q,   arlen_d;
    logic [2:0]            arsize_q,  arsize_d;
    logic [1:0]            arburst_q, arburst_d;

    logic [GW-1:0]         win;
    logic                  win_vld;

    // Routing never looks at the returned ID: one burst is outstanding at a time.
    logic unused_rid;
    assign unused_rid = ^s_axi_rid;

    // Winner search. In round-robin mode the scan starts at rr_ptr and wraps,
    // so the port just served is tried last on the next arbitration.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (FIXED_PRIO != 0) idx = k;
            else                 idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
            if (!win_vld && m_arvalid[idx]) begin
                win     = GW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    araddr_d  = m_araddr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    arlen_d   = m_arlen[win*8 +: 8];
                    arsize_d  = m_arsize[win*3 +: 3];
                    arburst_d = m_arburst[win*2 +: 2];
                    grant_d   = win;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (s_axi_arready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
        end
    end

    // Handshake decode: the AR ready is the capture pulse to the winner; during
    // DATA the owner's R handshake is wired straight through to the slave so
    // master backpressure stalls the slave directly.
    always_comb begin
        m_arready    = '0;
        m_rvalid     = '0;
        s_axi_rready = 1'b0;
        if (state_q == ST_IDLE && win_vld) m_arready[win] = 1'b1;
        if (state_q == ST_DATA) begin
            m_rvalid[grant_q] = s_axi_rvalid;
            s_axi_rready      = m_rready[grant_q];
        end
    end

    assign s_axi_arvalid = (state_q == ST_ADDR);
    assign s_axi_arid    = ID_WIDTH'(grant_q);
    assign s_axi_araddr  = araddr_q;
    assign s_axi_arlen   = arlen_q;
    assign s_axi_arsize  = arsize_q;
    assign s_axi_arburst = arburst_q;

    assign m_rdata = s_axi_rdata;
    assign m_rresp = s_axi_rresp;
    assign m_rlast = s_axi_rlast;

    assign grant_idx = grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_axi_rd_nx1_arb.sv
`timescale 1ns/1ps
// Bench for cpu_axi_rd_nx1_arb: instance 0 is 4-port round-robin, instance 1
// is 4-port fixed priority. Each has a small slave model whose read data is
// the beat address, so every beat identifies its burst and position.
module tb_cpu_axi_rd_nx1_arb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst       [2];
    logic [N*AW-1:0] m_araddr  [2];
    logic [N*8-1:0]  m_arlen   [2];
    logic [N*3-1:0]  m_arsize  [2];
    logic [N*2-1:0]  m_arburst [2];
    logic [N-1:0]    m_arvalid [2];
    logic [N-1:0]    m_arready [2];
    logic [N-1:0]    m_rvalid  [2];
    logic [N-1:0]    m_rready  [2];
    logic [DW-1:0]   m_rdata   [2];
    logic [1:0]      m_rresp   [2];
    logic            m_rlast   [2];
    logic [IW-1:0]   s_arid    [2];
    logic [AW-1:0]   s_araddr  [2];
    logic [7:0]      s_arlen   [2];
    logic [2:0]      s_arsize  [2];
    logic [1:0]      s_arburst [2];
    logic            s_arvalid [2];
    logic            s_arready [2];
    logic [IW-1:0]   s_rid     [2];
    logic [DW-1:0]   s_rdata   [2];
    logic [1:0]      s_rresp   [2];
    logic            s_rlast   [2];
    logic            s_rvalid  [2];
    logic            s_rready  [2];
    logic [1:0]      grant_idx [2];
    logic            busy      [2];
    logic            ar_en     [2];
    logic [7:0]      sl_beat   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic          busy_q;
        logic [AW-1:0] addr_q;
        logic [7:0]    len_q;
        logic [7:0]    beat_q;
        logic [IW-1:0] id_q;

        cpu_axi_rd_nx1_arb #(
            .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .FIXED_PRIO(g)
        ) u_dut (
            .clk(clk), .rst(rst[g]),
            .m_araddr(m_araddr[g]), .m_arlen(m_arlen[g]), .m_arsize(m_arsize[g]),
            .m_arburst(m_arburst[g]), .m_arvalid(m_arvalid[g]), .m_arready(m_arready[g]),
            .m_rdata(m_rdata[g]), .m_rresp(m_rresp[g]), .m_rlast(m_rlast[g]),
            .m_rvalid(m_rvalid[g]), .m_rready(m_rready[g]),
            .s_axi_arid(s_arid[g]), .s_axi_araddr(s_araddr[g]), .s_axi_arlen(s_arlen[g]),
            .s_axi_arsize(s_arsize[g]), .s_axi_arburst(s_arburst[g]),
            .s_axi_arvalid(s_arvalid[g]), .s_axi_arready(s_arready[g]),
            .s_axi_rid(s_rid[g]), .s_axi_rdata(s_rdata[g]), .s_axi_rresp(s_rresp[g]),
            .s_axi_rlast(s_rlast[g]), .s_axi_rvalid(s_rvalid[g]), .s_axi_rready(s_rready[g]),
            .grant_idx(grant_idx[g]), .busy(busy[g])
        );

        // Slave: accepts one AR, returns len+1 beats, data = addr + 4*beat, rresp = beat[1:0].
        assign s_arready[g] = ar_en[g] & ~busy_q;
        assign s_rvalid[g]  = busy_q;
        assign s_rdata[g]   = addr_q + (32'(beat_q) << 2);
        assign s_rresp[g]   = beat_q[1:0];
        assign s_rlast[g]   = (beat_q == len_q);
        assign s_rid[g]     = id_q;
        assign sl_beat[g]   = beat_q;

        always @(posedge clk) begin
            if (rst[g]) begin
                busy_q <= 1'b0; addr_q <= '0; len_q <= '0; beat_q <= '0; id_q <= '0;
            end else if (!busy_q) begin
                if (s_arvalid[g] && s_arready[g]) begin
                    busy_q <= 1'b1; addr_q <= s_araddr[g]; len_q <= s_arlen[g];
                    id_q <= s_arid[g]; beat_q <= '0;
                end
            end else if (s_rready[g]) begin
                if (s_rlast[g]) busy_q <= 1'b0;
                else            beat_q <= beat_q + 8'd1;
            end
        end
    end

    typedef struct { int g; int port; } gnt_t;
    typedef struct { int g; logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct { int g; int port; logic [DW-1:0] data; logic [1:0] resp; logic last; } beat_t;

    gnt_t  gq[$];
    ar_t   aq[$];
    beat_t bq[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Push the expected grant, slave AR and the first nb R beats of one burst.
    task automatic expect_burst(input int g, input int p, input logic [31:0] a,
                                input int len, input int nb);
        gnt_t e; ar_t r; beat_t b;
        e.g = g; e.port = p; gq.push_back(e);
        r.g = g; r.id = IW'(p); r.addr = a; r.len = 8'(len); aq.push_back(r);
        for (int i = 0; i < nb; i++) begin
            b.g = g; b.port = p; b.data = a + 32'(i * 4); b.resp = 2'(i); b.last = (i == len);
            bq.push_back(b);
        end
    endtask

    // Master: hold arvalid until arready, then drop it and scramble the fields
    // so a late capture would show up on the slave side.
    task automatic issue(input int g, input int p, input logic [31:0] a, input logic [7:0] len);
        int n;
        m_araddr[g][p*AW +: AW] = a;
        m_arlen[g][p*8 +: 8]    = len;
        m_arsize[g][p*3 +: 3]   = 3'd2;
        m_arburst[g][p*2 +: 2]  = 2'b01;
        m_arvalid[g][p]         = 1'b1;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!m_arready[g][p] && n < 300);
        if (!m_arready[g][p]) begin
            tests++; fails++;
            $display("FAIL ar_timeout inst %0d port %0d: arready 0, expected 1", g, p);
        end
        @(posedge clk); #1;
        m_arvalid[g][p]         = 1'b0;
        m_araddr[g][p*AW +: AW] = 32'hDEAD_0000 | 32'(p);
        m_arlen[g][p*8 +: 8]    = 8'hFF;
        m_arsize[g][p*3 +: 3]   = 3'd0;
        m_arburst[g][p*2 +: 2]  = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((gq.size() + aq.size() + bq.size()) != 0 && n < 400) begin
            @(negedge clk); n++;
        end
        chk("drain_pending", 64'(gq.size() + aq.size() + bq.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_idle(input int g);
        chk("rst_busy",      64'(busy[g]),      64'd0);
        chk("rst_m_arready", 64'(m_arready[g]), 64'd0);
        chk("rst_m_rvalid",  64'(m_rvalid[g]),  64'd0);
        chk("rst_s_rready",  64'(s_rready[g]),  64'd0);
        chk("rst_s_arvalid", 64'(s_arvalid[g]), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx[g]), 64'd0);
        chk("rst_s_araddr",  64'(s_araddr[g]),  64'd0);
    endtask

    // Monitor: pops and compares whenever a DUT handshake is presented.
    initial begin
        gnt_t e; ar_t r; beat_t b; logic [N-1:0] oh;
        forever begin
            @(negedge clk); #1;
            for (int g = 0; g < 2; g++) begin
                if (m_arready[g] != '0) begin
                    if (gq.size() == 0 || gq[0].g != g) begin
                        tests++; fails++;
                        $display("FAIL unexpected_grant inst %0d: m_arready=%b, expected none", g, m_arready[g]);
                    end else begin
                        e = gq.pop_front(); oh = '0; oh[e.port] = 1'b1;
                        chk("grant_onehot", 64'(m_arready[g]), 64'(oh));
                    end
                end
                if (s_arvalid[g] && s_arready[g]) begin
                    if (aq.size() == 0 || aq[0].g != g) begin
                        tests++; fails++;
                        $display("FAIL unexpected_ar inst %0d: araddr=%h, expected none", g, s_araddr[g]);
                    end else begin
                        r = aq.pop_front();
                        chk("ar_id",    64'(s_arid[g]),    64'(r.id));
                        chk("ar_addr",  64'(s_araddr[g]),  64'(r.addr));
                        chk("ar_len",   64'(s_arlen[g]),   64'(r.len));
                        chk("ar_size",  64'(s_arsize[g]),  64'd2);
                        chk("ar_burst", 64'(s_arburst[g]), 64'd1);
                    end
                end
                if (m_rvalid[g] != '0) begin
                    if (bq.size() == 0 || bq[0].g != g) begin
                        tests++; fails++;
                        $display("FAIL unexpected_beat inst %0d: m_rvalid=%b, expected none", g, m_rvalid[g]);
                    end else begin
                        oh = '0; oh[bq[0].port] = 1'b1;
                        chk("rvalid_owner", 64'(m_rvalid[g]), 64'(oh));
                        if ((m_rvalid[g] & m_rready[g]) != '0) begin
                            b = bq.pop_front();
                            chk("r_data",  64'(m_rdata[g]),   64'(b.data));
                            chk("r_resp",  64'(m_rresp[g]),   64'(b.resp));
                            chk("r_last",  64'(m_rlast[g]),   64'(b.last));
                            chk("r_grant", 64'(grant_idx[g]), 64'(b.port));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; ar_en[g] = 1'b1;
            m_araddr[g] = '0; m_arlen[g] = '0; m_arsize[g] = '0; m_arburst[g] = '0;
            m_arvalid[g] = '0; m_rready[g] = '1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_idle(0);
        chk_idle(1);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk); #1;

        // RR with ports 0 and 1 contending: 0,1,0,1.
        expect_burst(0, 0, 32'h1000, 0, 1);
        expect_burst(0, 1, 32'h2000, 0, 1);
        expect_burst(0, 0, 32'h1100, 0, 1);
        expect_burst(0, 1, 32'h2100, 0, 1);
        fork
            begin issue(0, 0, 32'h1000, 8'd0); issue(0, 0, 32'h1100, 8'd0); end
            begin issue(0, 1, 32'h2000, 8'd0); issue(0, 1, 32'h2100, 8'd0); end
        join
        drain();

        // Port 3 alone, 4 beats; pointer wraps to 0 so port 0 beats port 3 next.
        expect_burst(0, 3, 32'h3000, 3, 4);
        issue(0, 3, 32'h3000, 8'd3);
        drain();
        expect_burst(0, 0, 32'h4000, 0, 1);
        expect_burst(0, 3, 32'h5000, 1, 2);
        fork
            issue(0, 0, 32'h4000, 8'd0);
            issue(0, 3, 32'h5000, 8'd1);
        join
        drain();

        // Fixed priority: port 1 keeps winning until it stops asking.
        expect_burst(1, 1, 32'h6000, 1, 2);
        expect_burst(1, 1, 32'h6100, 0, 1);
        expect_burst(1, 1, 32'h6200, 2, 3);
        expect_burst(1, 2, 32'h7000, 0, 1);
        fork
            begin
                issue(1, 1, 32'h6000, 8'd1);
                issue(1, 1, 32'h6100, 8'd0);
                issue(1, 1, 32'h6200, 8'd2);
            end
            issue(1, 2, 32'h7000, 8'd0);
        join
        drain();

        // Slave AR stall for 5 cycles, then master R backpressure toggling.
        expect_burst(0, 2, 32'h8000, 3, 4);
        ar_en[0] = 1'b0;
        issue(0, 2, 32'h8000, 8'd3);
        repeat (5) begin
            @(negedge clk); #1;
            chk("stall_arvalid", 64'(s_arvalid[0]), 64'd1);
            chk("stall_araddr",  64'(s_araddr[0]),  64'h8000);
            chk("stall_arlen",   64'(s_arlen[0]),   64'd3);
            chk("stall_arid",    64'(s_arid[0]),    64'd2);
        end
        fork
            begin @(posedge clk); #1; ar_en[0] = 1'b1; end
            for (int i = 0; i < 16; i++) begin
                @(posedge clk); #1;
                m_rready[0][2] = i[0];
                m_rready[0][1] = ~i[1];
            end
        join
        m_rready[0] = '1;
        drain();

        // Reset during beat 2 of an 8-beat burst.
        expect_burst(0, 1, 32'h9000, 7, 3);
        issue(0, 1, 32'h9000, 8'd7);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!(sl_beat[0] == 8'd2 && s_rvalid[0]) && n < 100);
        chk("beat2_reached", 64'(sl_beat[0]), 64'd2);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy",     64'(busy[0]),      64'd0);
        chk("abort_m_rvalid", 64'(m_rvalid[0]),  64'd0);
        chk("abort_s_rready", 64'(s_rready[0]),  64'd0);
        chk("abort_arvalid",  64'(s_arvalid[0]), 64'd0);
        chk("abort_grant",    64'(grant_idx[0]), 64'd0);
        rst[0] = 1'b0;
        @(posedge clk); #1;
        // rr_ptr back at 0: port 2 must beat port 3.
        expect_burst(0, 2, 32'hA000, 0, 1);
        expect_burst(0, 3, 32'hA100, 0, 1);
        fork
            issue(0, 2, 32'hA000, 8'd0);
            issue(0, 3, 32'hA100, 8'd0);
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
